rv_fetch_unit: RTL and testbench

// - Instruction-fetch front end. Drives the instruction bus from the program counter.
// - Buffers returned words with their PCs and presents them to decode.
// - Reports instruction availability to the pipeline controller (i_fetch_bus_ack there).
// - Obeys the controller's fetch stall and the execute-stage redirect (pc_sel/target).

---
 rtl/rv_pkg.sv | 21 ++
 rtl/rv_fetch_fifo.sv | 65 ++++++
 rtl/rv_fetch_unit.sv | 131 +++++++++++++
 tb/tb_rv_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types for the instruction-fetch front end.
//   XLEN          : address / PC width
//   fetch_state_t : fetch FSM state encoding
//   fetch_entry_t : one buffered fetch result {pc, instr}
package rv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_REQ        = 2'd1,
      ST_WAIT_SPACE = 2'd2,
      ST_DRAIN      = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (accepted when not full, or when full with a pop)
//   pop        : remove the head (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   full,empty : occupancy flags, registered
//   count      : number of stored entries
//   head       : entry at the head (meaningful only when !empty)
module rv_fetch_fifo
   import rv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [AW:0]    cnt;
   logic           do_push;
   logic           do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign head    = mem[rd_ptr];

   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage carries no reset; the flags above define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: PC register, fetch FSM, bus drive, redirect handling,
// and a small buffer of fetched {pc, instr} entries presented to decode.
//   i_clk, i_reset_n       : clock, asynchronous active-low reset
//   i_stall                : decode not accepting; blocks pop of the head
//   i_pc_sel, i_pc_target  : redirect from execute (target bits [1:0] ignored)
//   o_bus_req, o_bus_addr  : instruction bus request / word address
//   i_bus_ack, i_bus_data  : single-cycle bus response with instruction word
//   o_valid, o_instr, o_pc : head of the instruction buffer
//   o_fetch_bus_ack        : copy of o_valid for the pipeline controller
//   o_dbg_state            : current fetch FSM state (fetch_state_t encoding)
//
// Handshakes: a bus request, once raised, is held with a stable address until
// i_bus_ack is seen, and is never withdrawn except by reset; to decode, an entry is
// transferred in every cycle where o_valid && !i_stall, and i_pc_sel overrides both
// directions (buffer flushed, nothing pushed or popped that cycle).
module rv_fetch_unit
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              FIFO_DEPTH   = 2
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_stall,
   input  logic            i_pc_sel,
   input  logic [XLEN-1:0] i_pc_target,
   output logic            o_bus_req,
   output logic [XLEN-1:0] o_bus_addr,
   input  logic            i_bus_ack,
   input  logic [31:0]     i_bus_data,
   output logic            o_valid,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic            o_fetch_bus_ack,
   output logic [1:0]      o_dbg_state
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            req_q;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_after;
   fetch_entry_t    fifo_din;
   fetch_entry_t    fifo_head;
   logic            unused_target_lsbs;

   assign unused_target_lsbs = ^i_pc_target[1:0];

   assign fifo_pop  = !fifo_empty && !i_stall;
   // Data acked in the redirect cycle belongs to the old path and is dropped.
   assign fifo_push = (state_q == ST_REQ) && i_bus_ack && !i_pc_sel;
   assign fifo_din  = '{pc: pc_q, instr: i_bus_data};

   // Occupancy after this cycle's push (only consulted when pushing).
   assign count_after = fifo_count + CW'(1) - CW'(fifo_pop);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (i_pc_sel) begin
         pc_d = {i_pc_target[XLEN-1:2], 2'b00};
         // A request still in flight must complete before the new path is fetched.
         if ((state_q == ST_REQ || state_q == ST_DRAIN) && !i_bus_ack)
            state_d = ST_DRAIN;
         else
            state_d = ST_REQ;
      end else begin
         case (state_q)
            ST_IDLE:       state_d = ST_REQ;
            ST_REQ: begin
               if (i_bus_ack) begin
                  pc_d    = pc_q + XLEN'(4);
                  state_d = (count_after == CW'(FIFO_DEPTH)) ? ST_WAIT_SPACE : ST_REQ;
               end
            end
            ST_WAIT_SPACE: if (!fifo_full) state_d = ST_REQ;
            ST_DRAIN:      if (i_bus_ack) state_d = ST_REQ;
            default:       state_d = ST_IDLE;
         endcase
      end
      // While draining, the stale address stays on the bus; otherwise the bus
      // address tracks the next PC.
      addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VECTOR;
         addr_q  <= RESET_VECTOR;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= (state_d == ST_REQ) || (state_d == ST_DRAIN);
      end
   end

   rv_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (i_pc_sel),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   assign o_bus_req       = req_q;
   assign o_bus_addr      = addr_q;
   assign o_valid         = !fifo_empty;
   assign o_fetch_bus_ack = !fifo_empty;
   assign o_instr         = fifo_empty ? 32'h0 : fifo_head.instr;
   assign o_pc            = fifo_empty ? '0 : fifo_head.pc;
   assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed scenarios followed by a randomized phase,
// all checked against an in-order program-stream model.
module tb_rv_fetch_unit;
   import rv_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_stall;
   logic        i_pc_sel;
   logic [31:0] i_pc_target;
   logic        o_bus_req;
   logic [31:0] o_bus_addr;
   logic        i_bus_ack;
   logic [31:0] i_bus_data;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_fetch_bus_ack;
   logic [1:0]  o_dbg_state;

   always #5 i_clk = ~i_clk;

   rv_fetch_unit #(
      .RESET_VECTOR (32'h0),
      .FIFO_DEPTH   (2)
   ) dut (
      .i_clk           (i_clk),
      .i_reset_n       (i_reset_n),
      .i_stall         (i_stall),
      .i_pc_sel        (i_pc_sel),
      .i_pc_target     (i_pc_target),
      .o_bus_req       (o_bus_req),
      .o_bus_addr      (o_bus_addr),
      .i_bus_ack       (i_bus_ack),
      .i_bus_data      (i_bus_data),
      .o_valid         (o_valid),
      .o_instr         (o_instr),
      .o_pc            (o_pc),
      .o_fetch_bus_ack (o_fetch_bus_ack),
      .o_dbg_state     (o_dbg_state)
   );

   // ---------------- scoreboard / reference model ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_pop = 0;
   logic [63:0] exp_q[$];     // {pc, instr} expected at decode, program order
   logic [31:0] fetch_pc;     // next address the program stream needs fetched
   logic        stale;        // an old-path request is still owed an ack
   logic        prev_hold;    // last cycle had a request without ack
   logic [31:0] prev_addr;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      fetch_pc  = 32'h0;
      stale     = 1'b0;
      prev_hold = 1'b0;
      prev_addr = 32'h0;
   endtask

   // Asserts reset (immediately), holds it two cycles, releases on a falling edge.
   task automatic do_reset();
      i_reset_n   = 1'b0;
      i_stall     = 1'b0;
      i_pc_sel    = 1'b0;
      i_pc_target = 32'h0;
      i_bus_ack   = 1'b0;
      i_bus_data  = 32'h0;
      model_clear();
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Called on a falling edge: samples outputs, drives inputs, updates the model,
   // and returns on the next falling edge.
   task automatic step(input logic st, input logic sel, input logic [31:0] tgt, input logic ack_en);
      logic        s_req, s_valid, ack;
      logic [31:0] s_addr, s_pc, s_instr;
      logic [63:0] e;
      s_req   = o_bus_req;
      s_addr  = o_bus_addr;
      s_valid = o_valid;
      s_pc    = o_pc;
      s_instr = o_instr;
      ack     = ack_en && s_req;

      i_stall     = st;
      i_pc_sel    = sel;
      i_pc_target = tgt;
      i_bus_ack   = ack;
      i_bus_data  = ack ? word_at(s_addr) : $urandom;

      chk("fetch_bus_ack", 32'(o_fetch_bus_ack), 32'(s_valid));
      chk("valid_vs_model", 32'(s_valid), 32'(exp_q.size() != 0));
      if (prev_hold) begin
         chk("req_held", 32'(s_req), 32'd1);
         chk("addr_stable", s_addr, prev_addr);
      end
      if (s_req) chk("addr_align", 32'(s_addr[1:0]), 32'd0);

      if (s_valid && !st && !sel && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("pop_pc", s_pc, e[63:32]);
         chk("pop_instr", s_instr, e[31:0]);
         n_pop++;
      end

      if (ack) begin
         if (stale) begin
            stale = 1'b0;
         end else begin
            chk("fetch_addr", s_addr, fetch_pc);
            if (!sel) exp_q.push_back({s_addr, word_at(s_addr)});
            fetch_pc = fetch_pc + 32'd4;
         end
      end
      if (sel) begin
         exp_q.delete();
         fetch_pc = {tgt[31:2], 2'b00};
         if (s_req && !ack) stale = 1'b1;
      end

      prev_hold = s_req && !ack;
      prev_addr = s_addr;
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic        r_st, r_sel, r_ack;
      logic [31:0] r_tgt;

      i_reset_n = 1'b1;
      #1;
      do_reset();

      // Reset state
      chk("rst_req", 32'(o_bus_req), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_fba", 32'(o_fetch_bus_ack), 32'd0);
      chk("rst_instr", o_instr, 32'h0);
      chk("rst_pc", o_pc, 32'h0);

      // Back-to-back fetch with ack every cycle
      step(0, 0, 0, 1);
      chk("t1_req", 32'(o_bus_req), 32'd1);
      chk("t1_addr0", o_bus_addr, 32'h0);
      step(0, 0, 0, 1);
      chk("t1_addr4", o_bus_addr, 32'h4);
      chk("t1_valid", 32'(o_valid), 32'd1);
      chk("t1_pc", o_pc, 32'h0);
      chk("t1_instr", o_instr, 32'h13);
      step(0, 0, 0, 1);
      chk("t1_addr8", o_bus_addr, 32'h8);

      // Stall fills the buffer, request drops, then resumes at 0x8
      do_reset();
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("t2_req_drop", 32'(o_bus_req), 32'd0);
      chk("t2_head0", o_pc, 32'h0);
      step(1, 0, 0, 1);
      chk("t2_req_still0", 32'(o_bus_req), 32'd0);
      step(0, 0, 0, 1);
      chk("t2_head4", o_pc, 32'h4);
      step(0, 0, 0, 1);
      chk("t2_reissue_req", 32'(o_bus_req), 32'd1);
      chk("t2_reissue_addr", o_bus_addr, 32'h8);
      chk("t2_empty", 32'(o_valid), 32'd0);

      // Redirect while 0x8 is unacked; ack three cycles later
      step(0, 1, 32'h100, 0);
      chk("t3_req_kept", 32'(o_bus_req), 32'd1);
      chk("t3_stale_addr", o_bus_addr, 32'h8);
      chk("t3_valid0", 32'(o_valid), 32'd0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("t3_valid_after_drain", 32'(o_valid), 32'd0);
      chk("t3_addr100", o_bus_addr, 32'h100);
      step(0, 0, 0, 1);
      chk("t3_head_pc", o_pc, 32'h100);
      chk("t3_head_instr", o_instr, 32'h113);

      // Redirect to 0x203 in the same cycle as an ack
      step(0, 1, 32'h203, 1);
      chk("t4_valid0", 32'(o_valid), 32'd0);
      chk("t4_addr200", o_bus_addr, 32'h200);
      chk("t4_req", 32'(o_bus_req), 32'd1);

      // Full buffer, pop and redirect together
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("t5_full_req0", 32'(o_bus_req), 32'd0);
      chk("t5_head200", o_pc, 32'h200);
      step(0, 1, 32'h300, 0);
      chk("t5_flushed", 32'(o_valid), 32'd0);
      chk("t5_addr300", o_bus_addr, 32'h300);
      step(1, 0, 0, 1);
      chk("t5_head300", o_pc, 32'h300);
      chk("t5_req_on", 32'(o_bus_req), 32'd1);

      // Asynchronous reset between edges while a request is outstanding
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("t6_req_async", 32'(o_bus_req), 32'd0);
      chk("t6_valid_async", 32'(o_valid), 32'd0);
      chk("t6_fba_async", 32'(o_fetch_bus_ack), 32'd0);
      do_reset();
      step(0, 0, 0, 1);
      chk("t6_restart_req", 32'(o_bus_req), 32'd1);
      chk("t6_restart_addr", o_bus_addr, 32'h0);

      // PC wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFF9, 0);
      step(0, 0, 0, 1);
      chk("t7_addr_f8", o_bus_addr, 32'hFFFF_FFF8);
      step(0, 0, 0, 1);
      chk("t7_addr_fc", o_bus_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1);
      chk("t7_addr_wrap", o_bus_addr, 32'h0);

      // Randomized traffic against the program-stream model
      for (int i = 0; i < 3000; i++) begin
         r_st  = ($urandom_range(0, 3) == 0);
         r_sel = ($urandom_range(0, 19) == 0);
         r_ack = ($urandom_range(0, 2) != 0);
         r_tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
         step(r_st, r_sel, r_tgt, r_ack);
      end
      chk("progress", 32'(n_pop > 200), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
